i2c_init_sequencer: RTL

//  Upstream command source for i2c_controller. On a go pulse, walks a fixed table of

---
 rtl/i2c_init_sequencer_pkg.sv | 39 +++
 rtl/i2c_init_rom.sv | 25 ++
 rtl/i2c_init_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/i2c_init_sequencer_pkg.sv
// Shared types and entry layout for the I2C init sequencer and its command ROM.
package i2c_init_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_ACK,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int         ENTRY_W   = 24;
  localparam int         DEV_LSB   = 16;
  localparam int         REG_LSB   = 8;
  localparam int         DAT_LSB   = 0;
  localparam logic [7:0] DELAY_DEV = 8'hFF;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [7:0] dev,
                                                  input logic [7:0] rga,
                                                  input logic [7:0] dat);
    return {dev, rga, dat};
  endfunction

  function automatic logic [7:0] ent_dev(input logic [ENTRY_W-1:0] e);
    return e[DEV_LSB +: 8];
  endfunction

  function automatic logic [7:0] ent_reg(input logic [ENTRY_W-1:0] e);
    return e[REG_LSB +: 8];
  endfunction

  function automatic logic [7:0] ent_dat(input logic [ENTRY_W-1:0] e);
    return e[DAT_LSB +: 8];
  endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Board-specific register-write table; combinational lookup by entry index.
module i2c_init_rom
  import i2c_init_sequencer_pkg::*;
(
  input  logic [7:0]         i_index,
  output logic [ENTRY_W-1:0] o_entry
);

  // Unused slots decode as zero-length delays so a short table is harmless.
  always_comb begin
    o_entry = mk_entry(DELAY_DEV, 8'h00, 8'h00);
    case (i_index)
      8'd0:    o_entry = mk_entry(8'hA0, 8'h10, 8'h55);
      8'd1:    o_entry = mk_entry(8'hA0, 8'h11, 8'hAA);
      8'd2:    o_entry = mk_entry(DELAY_DEV, 8'h03, 8'h00);
      8'd3:    o_entry = mk_entry(8'hA0, 8'h12, 8'h01);
      8'd4:    o_entry = mk_entry(DELAY_DEV, 8'h0A, 8'h00);
      8'd5:    o_entry = mk_entry(8'hA0, 8'h13, 8'h3C);
      8'd6:    o_entry = mk_entry(8'hA0, 8'h14, 8'hC3);
      8'd7:    o_entry = mk_entry(8'hA0, 8'h15, 8'h00);
      default: ;
    endcase
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init ROM on a go pulse, issuing each write through the controller's
// start/ready handshake, with inline delay entries and a per-phase timeout.
module i2c_init_sequencer
  import i2c_init_sequencer_pkg::*;
#(
  parameter int NUM_CMDS       = 8,
  parameter int DELAY_UNIT     = 50000,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       i_clk_in,
  input  logic       i_reset,
  input  logic       i_go,
  input  logic       i_i2c_ready,
  output logic       o_start,
  output logic [7:0] o_dev_addr,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [7:0] o_cmd_index
);

  localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]       LAST_IDX   = 8'(NUM_CMDS - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DLY_W-1:0] DLY_UNIT_W = DLY_W'(DELAY_UNIT);

  if (NUM_CMDS < 1 || NUM_CMDS > 256) begin : g_bad_num_cmds
    $error("i2c_init_sequencer: NUM_CMDS must be in 1..256");
  end

  state_t             r_state;
  state_t             w_next;
  logic               r_rdy_meta;
  logic               r_rdy_s;
  logic [7:0]         r_cmd_index;
  logic [7:0]         r_dev;
  logic [7:0]         r_reg;
  logic [7:0]         r_dat;
  logic               r_error;
  logic [DLY_W-1:0]   r_dly;
  logic [TMO_W-1:0]   r_tmo;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_is_delay;
  logic               w_tmo_hit;

  always_ff @(posedge i_clk_in or negedge i_reset) begin
    if (!i_reset) begin
      r_rdy_meta <= 1'b0;
      r_rdy_s    <= 1'b0;
    end else begin
      r_rdy_meta <= i_i2c_ready;
      r_rdy_s    <= r_rdy_meta;
    end
  end

  i2c_init_rom u_rom (
    .i_index (r_cmd_index),
    .o_entry (w_entry)
  );

  assign w_is_delay = (ent_dev(w_entry) == DELAY_DEV);
  assign w_tmo_hit  = (r_tmo >= TMO_LAST);

  always_ff @(posedge i_clk_in or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Handshake outputs are decoded from state so reset drops start without a clock.
  always_comb begin
    w_next  = r_state;
    o_start = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_go && r_rdy_s) w_next = ST_LOAD;
      ST_LOAD: begin
        o_busy = 1'b1;
        w_next = w_is_delay ? ST_DELAY : ST_REQ;
      end
      ST_REQ: begin
        o_busy  = 1'b1;
        o_start = 1'b1;
        if (!r_rdy_s)       w_next = ST_ACK;
        else if (w_tmo_hit) w_next = ST_ERR;
      end
      ST_ACK: begin
        o_busy = 1'b1;
        if (r_rdy_s)        w_next = ST_NEXT;
        else if (w_tmo_hit) w_next = ST_ERR;
      end
      ST_DELAY: begin
        o_busy = 1'b1;
        if (r_dly <= DLY_W'(1)) w_next = ST_NEXT;
      end
      ST_NEXT: begin
        o_busy = 1'b1;
        w_next = (r_cmd_index == LAST_IDX) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      ST_ERR:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_in or negedge i_reset) begin
    if (!i_reset) begin
      r_cmd_index <= 8'd0;
      r_error     <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_next == ST_LOAD) begin
        r_cmd_index <= 8'd0;
        r_error     <= 1'b0;
      end else if (r_state == ST_NEXT && w_next == ST_LOAD) begin
        r_cmd_index <= r_cmd_index + 8'd1;
      end
      if (w_next == ST_ERR) r_error <= 1'b1;
    end
  end

  // A delay of N ticks occupies DELAY for exactly N*DELAY_UNIT cycles (min 1).
  always_ff @(posedge i_clk_in or negedge i_reset) begin
    if (!i_reset) begin
      r_dev <= 8'd0;
      r_reg <= 8'd0;
      r_dat <= 8'd0;
      r_dly <= '0;
    end else if (r_state == ST_LOAD) begin
      r_dev <= ent_dev(w_entry);
      r_reg <= ent_reg(w_entry);
      r_dat <= ent_dat(w_entry);
      r_dly <= DLY_W'(ent_reg(w_entry)) * DLY_UNIT_W;
    end else if (r_state == ST_DELAY && r_dly != '0) begin
      r_dly <= r_dly - DLY_W'(1);
    end
  end

  always_ff @(posedge i_clk_in or negedge i_reset) begin
    if (!i_reset) begin
      r_tmo <= '0;
    end else if ((w_next == ST_REQ || w_next == ST_ACK) && w_next != r_state) begin
      r_tmo <= '0;
    end else if ((r_state == ST_REQ || r_state == ST_ACK) && r_tmo != TMO_LIMIT) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign o_dev_addr  = r_dev;
  assign o_reg_addr  = r_reg;
  assign o_data      = r_dat;
  assign o_error     = r_error;
  assign o_cmd_index = r_cmd_index;

endmodule
